axi_bootrom_responder: RTL and testbench

- AXI4 subordinate (responder) for the boot ROM region at 0x1_0000, length 0x1_0000. It sits on the far end of the core's AXI4 manager port (ID 4 b, address 64 b, data 64 b).
- Serves read bursts from a synchronous 1-cycle-latency ROM macro.
- Rejects all writes with SLVERR. Read and write paths are independent.

---
 rtl/bootrom_resp_pkg.sv | 33 +++
 rtl/axi_bootrom_wr_sink.sv | 84 ++++++++
 rtl/axi_bootrom_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_bootrom_responder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootrom_resp_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : bootrom_resp_pkg                                             |
// | Description : FSM encodings and AXI response/burst codes for the boot ROM  |
// |               responder.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package bootrom_resp_pkg;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_WAIT  = 2'd2,
        R_SEND  = 2'd3
    } read_state_e;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_DRAIN = 2'd1,
        W_RESP  = 2'd2
    } write_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axi_bootrom_wr_sink.sv
// +----------------------------------------------------------------------------+
// | Module      : axi_bootrom_wr_sink                                          |
// | Description : AW/W/B path; drains every write burst and answers SLVERR.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_bootrom_wr_sink
    import bootrom_resp_pkg::*;
#(
    parameter int unsigned AxiIdWidth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [AxiIdWidth-1:0] aw_id_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic                  w_last_i,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [AxiIdWidth-1:0] b_id_o,
    output logic [1:0]            b_resp_o
);

    write_state_e          state_q, state_d;
    logic [AxiIdWidth-1:0] id_q, id_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= W_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            W_IDLE: begin
                if (aw_valid_i) begin
                    id_d    = aw_id_i;
                    state_d = W_DRAIN;
                end
            end
            W_DRAIN: begin
                if (w_valid_i && w_last_i) begin
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        b_id_o     = '0;
        b_resp_o   = RESP_OKAY;
        case (state_q)
            W_IDLE:  aw_ready_o = 1'b1;
            W_DRAIN: w_ready_o  = 1'b1;
            W_RESP: begin
                b_valid_o = 1'b1;
                b_id_o    = id_q;
                b_resp_o  = RESP_SLVERR;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi_bootrom_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : axi_bootrom_responder                                        |
// | Description : AXI4 subordinate serving read bursts from a 1-cycle ROM and  |
// |               rejecting writes. CVA6_BOOTROM_ERR_CNT_EN adds err_cnt_o.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_bootrom_responder
    import bootrom_resp_pkg::*;
#(
    parameter int unsigned                AxiIdWidth   = 4,
    parameter int unsigned                AxiAddrWidth = 64,
    parameter int unsigned                AxiDataWidth = 64,
    parameter logic [AxiAddrWidth-1:0]    BaseAddr     = 'h1_0000,
    parameter logic [AxiAddrWidth-1:0]    RomBytes     = 'h1_0000,
    parameter int unsigned                RomAddrWidth = $clog2(RomBytes / 8)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [AxiIdWidth-1:0]   ar_id_i,
    input  logic [AxiAddrWidth-1:0] ar_addr_i,
    input  logic [7:0]              ar_len_i,
    input  logic [2:0]              ar_size_i,
    input  logic [1:0]              ar_burst_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [AxiIdWidth-1:0]   r_id_o,
    output logic [AxiDataWidth-1:0] r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [AxiIdWidth-1:0]   aw_id_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic                    w_last_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [AxiIdWidth-1:0]   b_id_o,
    output logic [1:0]              b_resp_o,
    output logic                    rom_req_o,
    output logic [RomAddrWidth-1:0] rom_addr_o,
    input  logic [AxiDataWidth-1:0] rom_rdata_i
`ifdef CVA6_BOOTROM_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt_o
`endif
);

    localparam logic [AxiAddrWidth-1:0] c_ROM_END = BaseAddr + RomBytes;
    localparam logic [AxiAddrWidth-1:0] c_ONE     = {{(AxiAddrWidth-1){1'b0}}, 1'b1};

    read_state_e             state_q, state_d;
    logic [AxiIdWidth-1:0]   id_q, id_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              beat_q, beat_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [AxiDataWidth-1:0] data_q, data_d;
    logic                    err_q, err_d;

    logic                    w_addr_err;
    logic                    w_last_beat;
    logic [AxiAddrWidth-1:0] w_off;
    logic [AxiAddrWidth-1:0] w_step;
    logic [AxiAddrWidth-1:0] w_next_addr;
    logic                    w_unused;

    // Error is judged from the current beat address, so an INCR burst that
    // walks off the end of the region turns to SLVERR from that beat onward.
    assign w_addr_err  = (addr_q < BaseAddr) || (addr_q >= c_ROM_END) ||
                         (burst_q == BURST_WRAP) || (size_q > 3'd3);
    assign w_last_beat = (beat_q == len_q);
    assign w_off       = addr_q - BaseAddr;
    assign w_step      = c_ONE << size_q;
    assign w_next_addr = (addr_q & ~(w_step - c_ONE)) + w_step;
    assign w_unused    = ^{w_off[AxiAddrWidth-1:RomAddrWidth+3], w_off[2:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (ar_valid_i) state_d = R_FETCH;
            R_FETCH: state_d = R_WAIT;
            R_WAIT:  state_d = R_SEND;
            R_SEND:  if (r_ready_i) state_d = w_last_beat ? R_IDLE : R_FETCH;
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        size_d  = size_q;
        burst_d = burst_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    id_d    = ar_id_i;
                    addr_d  = ar_addr_i;
                    len_d   = ar_len_i;
                    size_d  = ar_size_i;
                    burst_d = ar_burst_i;
                    beat_d  = '0;
                end
            end
            R_WAIT: begin
                data_d = w_addr_err ? '0 : rom_rdata_i;
                err_d  = w_addr_err;
            end
            R_SEND: begin
                if (r_ready_i && !w_last_beat) begin
                    beat_d = beat_q + 8'd1;
                    if (burst_q == BURST_INCR) begin
                        addr_d = w_next_addr;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ar_ready_o = 1'b0;
        rom_req_o  = 1'b0;
        rom_addr_o = '0;
        r_valid_o  = 1'b0;
        r_id_o     = '0;
        r_data_o   = '0;
        r_resp_o   = RESP_OKAY;
        r_last_o   = 1'b0;
        case (state_q)
            R_IDLE: ar_ready_o = 1'b1;
            R_FETCH: begin
                if (!w_addr_err) begin
                    rom_req_o  = 1'b1;
                    rom_addr_o = w_off[RomAddrWidth+2:3];
                end
            end
            R_SEND: begin
                r_valid_o = 1'b1;
                r_id_o    = id_q;
                r_data_o  = data_q;
                r_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
                r_last_o  = w_last_beat;
            end
            default: ;
        endcase
    end

    axi_bootrom_wr_sink #(
        .AxiIdWidth (AxiIdWidth)
    ) u_wr_sink (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_id_i    (aw_id_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .w_last_i   (w_last_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o)
    );

`ifdef CVA6_BOOTROM_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    // R and B error handshakes can coincide, so the step is 0, 1 or 2.
    always_comb begin
        w_err_inc = {1'b0, r_valid_o && r_ready_i && (r_resp_o == RESP_SLVERR)} +
                    {1'b0, b_valid_o && b_ready_i && (b_resp_o == RESP_SLVERR)};
        w_err_sum = {1'b0, err_cnt_q} + {15'd0, w_err_inc};
        err_cnt_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_bootrom_responder.sv
// Directed self-checking bench for axi_bootrom_responder; the bench models the
// 1-cycle ROM macro with a fixed content pattern.
`default_nettype none

module tb_axi_bootrom_responder;
    import bootrom_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_id;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_id;
    logic        w_valid, w_ready, w_last;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        rom_req;
    logic [12:0] rom_addr;
    logic [63:0] rom_rdata;
`ifdef CVA6_BOOTROM_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int rom_req_cnt = 0;

    logic [63:0] g_data [16];
    logic [1:0]  g_resp [16];
    logic        g_last [16];
    logic [3:0]  g_id   [16];
    int          g_gap  [16];
    int          g_n;
    bit          g_to;
    bit          g_stable;
    logic        g_req1;
    logic [12:0] g_raddr1;

    always #5 clk = ~clk;

    axi_bootrom_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .ar_valid_i  (ar_valid),
        .ar_ready_o  (ar_ready),
        .ar_id_i     (ar_id),
        .ar_addr_i   (ar_addr),
        .ar_len_i    (ar_len),
        .ar_size_i   (ar_size),
        .ar_burst_i  (ar_burst),
        .r_valid_o   (r_valid),
        .r_ready_i   (r_ready),
        .r_id_o      (r_id),
        .r_data_o    (r_data),
        .r_resp_o    (r_resp),
        .r_last_o    (r_last),
        .aw_valid_i  (aw_valid),
        .aw_ready_o  (aw_ready),
        .aw_id_i     (aw_id),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .w_last_i    (w_last),
        .b_valid_o   (b_valid),
        .b_ready_i   (b_ready),
        .b_id_o      (b_id),
        .b_resp_o    (b_resp),
        .rom_req_o   (rom_req),
        .rom_addr_o  (rom_addr),
        .rom_rdata_i (rom_rdata)
`ifdef CVA6_BOOTROM_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt)
`endif
    );

    function automatic logic [63:0] romv(input int i);
        logic [15:0] x;
        x = i[15:0];
        return {16'hB007, x, ~x, 16'h5AA5};
    endfunction

    always @(posedge clk) begin
        if (rom_req) begin
            rom_rdata   <= romv(int'(rom_addr));
            rom_req_cnt <= rom_req_cnt + 1;
        end
    end

    // Issues one AR and collects every R beat; stalls r_ready on one beat.
    task automatic run_read(input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int stall_beat,
                            input int stall_cyc);
        int cyc, held, last_acc;
        bit seen;
        logic [70:0] snap;
        g_n = 0; g_to = 0; g_stable = 1; g_req1 = 0; g_raddr1 = '0;
        held = 0; last_acc = 0; cyc = 0; seen = 0; snap = '0;
        @(negedge clk);
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len;
        ar_size = size; ar_burst = burst; r_ready = 1;
        while (!ar_ready && cyc < 20) begin @(negedge clk); cyc++; end
        if (!ar_ready) g_to = 1;
        @(posedge clk); #1 ar_valid = 0;
        cyc = 0;
        while (g_n <= int'(len) && g_n < 16 && cyc < 200) begin
            @(negedge clk); cyc++;
            if (cyc == 1) begin g_req1 = rom_req; g_raddr1 = rom_addr; end
            if (r_valid) begin
                if (!seen) begin
                    g_gap[g_n] = cyc - last_acc;
                    snap = {r_data, r_last, r_id, r_resp};
                    seen = 1;
                end else if ({r_data, r_last, r_id, r_resp} !== snap) begin
                    g_stable = 0;
                end
                if (g_n == stall_beat && held < stall_cyc) begin
                    r_ready = 0; held++;
                end else begin
                    r_ready = 1;
                    g_data[g_n] = r_data; g_resp[g_n] = r_resp;
                    g_last[g_n] = r_last; g_id[g_n] = r_id;
                    g_n++; last_acc = cyc; seen = 0;
                end
            end
        end
        if (g_n <= int'(len)) g_to = 1;
    endtask

    task automatic test_reset();
        logic [95:0] obs;
        rst_n = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        r_ready = 1; aw_valid = 0; aw_id = 0; w_valid = 0; w_last = 0; b_ready = 0;
        repeat (3) @(negedge clk);
        obs = {ar_ready, aw_ready, r_valid, r_data, r_id, r_resp, r_last,
               w_ready, b_valid, b_id, b_resp, rom_req, rom_addr};
        n_vec++;
        if (obs !== {2'b11, 94'd0}) begin
            n_miss++; $display("FAIL reset_outputs: got %h want %h", obs, {2'b11, 94'd0});
        end
        rst_n = 1;
        @(negedge clk);
        obs = {ar_ready, aw_ready, r_valid, r_data, r_id, r_resp, r_last,
               w_ready, b_valid, b_id, b_resp, rom_req, rom_addr};
        n_vec++;
        if (obs !== {2'b11, 94'd0}) begin
            n_miss++; $display("FAIL reset_release: got %h want %h", obs, {2'b11, 94'd0});
        end
`ifdef CVA6_BOOTROM_ERR_CNT_EN
        n_vec++;
        if (err_cnt !== 16'd0) begin n_miss++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
`endif
    endtask

    task automatic test_single();
        logic [70:0] exp, got;
        run_read(4'd3, 64'h1_0000, 8'd0, 3'd3, BURST_INCR, -1, 0);
        n_vec++;
        if (g_to || g_n != 1) begin n_miss++; $display("FAIL single_count: got %0d beats to=%0b want 1", g_n, g_to); end
        n_vec++;
        if ({g_req1, g_raddr1} !== {1'b1, 13'd0}) begin
            n_miss++; $display("FAIL single_romreq: got req=%b addr=%0d want req=1 addr=0", g_req1, g_raddr1);
        end
        n_vec++;
        if (g_gap[0] != 3) begin n_miss++; $display("FAIL single_latency: got %0d want 3", g_gap[0]); end
        exp = {romv(0), RESP_OKAY, 1'b1, 4'd3};
        got = {g_data[0], g_resp[0], g_last[0], g_id[0]};
        n_vec++;
        if (got !== exp) begin n_miss++; $display("FAIL single_beat: got %h want %h", got, exp); end
        @(negedge clk);
        n_vec++;
        if ({ar_ready, r_valid} !== 2'b10) begin
            n_miss++; $display("FAIL single_idle: got ar_ready=%b r_valid=%b want 1 0", ar_ready, r_valid);
        end
    endtask

    task automatic test_burst();
        logic [67:0] exp, got;
        run_read(4'd1, 64'h1_0008, 8'd3, 3'd3, BURST_INCR, -1, 0);
        n_vec++;
        if (g_to || g_n != 4) begin n_miss++; $display("FAIL burst_count: got %0d want 4", g_n); end
        for (int b = 0; b < 4; b++) begin
            exp = {romv(1 + b), RESP_OKAY, (b == 3), 1'b1};
            got = {g_data[b], g_resp[b], g_last[b], g_gap[b] == 3};
            n_vec++;
            if (got !== exp) begin n_miss++; $display("FAIL burst_beat%0d: got %h want %h (gap %0d)", b, got, exp, g_gap[b]); end
        end
        // FIXED repeats the same word; size 2 INCR steps by 4 bytes
        run_read(4'd2, 64'h1_0018, 8'd2, 3'd3, BURST_FIXED, -1, 0);
        for (int b = 0; b < 3; b++) begin
            exp = {romv(3), RESP_OKAY, (b == 2), 1'b1};
            got = {g_data[b], g_resp[b], g_last[b], g_n == 3};
            n_vec++;
            if (got !== exp) begin n_miss++; $display("FAIL fixed_beat%0d: got %h want %h", b, got, exp); end
        end
        run_read(4'd2, 64'h1_0004, 8'd1, 3'd2, BURST_INCR, -1, 0);
        for (int b = 0; b < 2; b++) begin
            exp = {romv(b), RESP_OKAY, (b == 1), 1'b1};
            got = {g_data[b], g_resp[b], g_last[b], g_n == 2};
            n_vec++;
            if (got !== exp) begin n_miss++; $display("FAIL narrow_beat%0d: got %h want %h", b, got, exp); end
        end
    endtask

    task automatic test_error();
        logic [63:0] t_addr [5];
        logic [1:0]  t_burst[5];
        logic [2:0]  t_size [5];
        logic [7:0]  t_len  [5];
        int          t_ok   [5];
        int          req0;
        logic [66:0] exp, got;
`ifdef CVA6_BOOTROM_ERR_CNT_EN
        logic [15:0] e0;
`endif
        t_addr  = '{64'h8000_0000, 64'h1_0000, 64'h0_FFF8, 64'h1_0000, 64'h1_FFF8};
        t_burst = '{BURST_INCR, BURST_WRAP, BURST_INCR, BURST_INCR, BURST_INCR};
        t_size  = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd3};
        t_len   = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
        t_ok    = '{0, 0, 0, 0, 1};
        for (int c = 0; c < 5; c++) begin
            req0 = rom_req_cnt;
`ifdef CVA6_BOOTROM_ERR_CNT_EN
            e0 = err_cnt;
`endif
            run_read(4'(c + 8), t_addr[c], t_len[c], t_size[c], t_burst[c], -1, 0);
            @(negedge clk);
            n_vec++;
            if (g_to || g_n != int'(t_len[c]) + 1) begin
                n_miss++; $display("FAIL err%0d_count: got %0d want %0d", c, g_n, int'(t_len[c]) + 1);
            end
            for (int b = 0; b <= int'(t_len[c]); b++) begin
                exp = (b < t_ok[c]) ? {romv(32'h1FFF + b), RESP_OKAY, b == int'(t_len[c])}
                                    : {64'd0, RESP_SLVERR, b == int'(t_len[c])};
                got = {g_data[b], g_resp[b], g_last[b]};
                n_vec++;
                if (got !== exp) begin n_miss++; $display("FAIL err%0d_beat%0d: got %h want %h", c, b, got, exp); end
            end
            n_vec++;
            if (rom_req_cnt - req0 != t_ok[c]) begin
                n_miss++; $display("FAIL err%0d_romreq: got %0d strobes want %0d", c, rom_req_cnt - req0, t_ok[c]);
            end
`ifdef CVA6_BOOTROM_ERR_CNT_EN
            n_vec++;
            if (err_cnt - e0 !== 16'(int'(t_len[c]) + 1 - t_ok[c])) begin
                n_miss++; $display("FAIL err%0d_errcnt: got +%0d want +%0d", c, err_cnt - e0, int'(t_len[c]) + 1 - t_ok[c]);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [67:0] exp, got;
        run_read(4'd6, 64'h1_0020, 8'd2, 3'd3, BURST_INCR, 1, 5);
        n_vec++;
        if (g_stable !== 1'b1) begin n_miss++; $display("FAIL bp_stable: got %b want 1", g_stable); end
        n_vec++;
        if (g_to || g_n != 3) begin n_miss++; $display("FAIL bp_count: got %0d want 3", g_n); end
        for (int b = 0; b < 3; b++) begin
            exp = {romv(4 + b), (b == 2), g_id[b] == 4'd6, g_gap[b] == 3, 1'b1};
            got = {g_data[b], g_last[b], 1'b1, 1'b1, g_resp[b] == RESP_OKAY};
            n_vec++;
            if (got !== exp) begin n_miss++; $display("FAIL bp_beat%0d: got %h want %h", b, got, exp); end
        end
    endtask

    task automatic test_concurrent();
        logic [66:0] exp, got;
`ifdef CVA6_BOOTROM_ERR_CNT_EN
        logic [15:0] e0;
        e0 = err_cnt;
`endif
        fork
            run_read(4'd9, 64'h1_0000, 8'd1, 3'd3, BURST_INCR, -1, 0);
            begin
                int cyc;
                @(negedge clk);
                n_vec++;
                if ({aw_ready, w_ready} !== 2'b10) begin
                    n_miss++; $display("FAIL wr_idle: got aw_ready=%b w_ready=%b want 1 0", aw_ready, w_ready);
                end
                aw_valid = 1; aw_id = 4'd5; w_valid = 1; w_last = 0;
                @(posedge clk); #1 aw_valid = 0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    w_last = (k == 2);
                    n_vec++;
                    if (w_ready !== 1'b1) begin n_miss++; $display("FAIL wr_drain%0d: got w_ready=%b want 1", k, w_ready); end
                    @(posedge clk); #1;
                end
                w_valid = 0; w_last = 0;
                cyc = 0;
                @(negedge clk);
                while (!b_valid && cyc < 20) begin @(negedge clk); cyc++; end
                n_vec++;
                if ({b_valid, b_resp, b_id, w_ready} !== {1'b1, RESP_SLVERR, 4'd5, 1'b0}) begin
                    n_miss++; $display("FAIL wr_bresp: got v=%b resp=%b id=%0d want v=1 resp=10 id=5", b_valid, b_resp, b_id);
                end
                b_ready = 1;
                @(posedge clk); #1 b_ready = 0;
                @(negedge clk);
                n_vec++;
                if ({b_valid, aw_ready} !== 2'b01) begin
                    n_miss++; $display("FAIL wr_done: got b_valid=%b aw_ready=%b want 0 1", b_valid, aw_ready);
                end
            end
        join
        @(negedge clk);
        n_vec++;
        if (g_to || g_n != 2) begin n_miss++; $display("FAIL conc_count: got %0d want 2", g_n); end
        for (int b = 0; b < 2; b++) begin
            exp = {romv(b), RESP_OKAY, b == 1};
            got = {g_data[b], g_resp[b], g_last[b]};
            n_vec++;
            if (got !== exp || g_gap[b] != 3 || g_id[b] !== 4'd9) begin
                n_miss++; $display("FAIL conc_beat%0d: got %h gap %0d id %0d want %h gap 3 id 9", b, got, g_gap[b], g_id[b], exp);
            end
        end
`ifdef CVA6_BOOTROM_ERR_CNT_EN
        n_vec++;
        if (err_cnt - e0 !== 16'd1) begin n_miss++; $display("FAIL conc_errcnt: got +%0d want +1", err_cnt - e0); end
`endif
    endtask

    task automatic test_reset_midburst();
        int cyc, seen;
        logic [95:0] obs;
        logic [67:0] exp, got;
        @(negedge clk);
        ar_valid = 1; ar_id = 4'hA; ar_addr = 64'h1_0000; ar_len = 8'd3;
        ar_size = 3'd3; ar_burst = BURST_INCR; r_ready = 1;
        @(posedge clk); #1 ar_valid = 0;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 50) begin
            @(negedge clk); cyc++;
            if (r_valid) seen++;
        end
        n_vec++;
        if (seen != 2) begin n_miss++; $display("FAIL rst_mid_reach: got %0d beats want 2", seen); end
        rst_n = 0;
        #1;
        obs = {ar_ready, aw_ready, r_valid, r_data, r_id, r_resp, r_last,
               w_ready, b_valid, b_id, b_resp, rom_req, rom_addr};
        n_vec++;
        if (obs !== {2'b11, 94'd0}) begin
            n_miss++; $display("FAIL rst_mid_outputs: got %h want %h", obs, {2'b11, 94'd0});
        end
`ifdef CVA6_BOOTROM_ERR_CNT_EN
        n_vec++;
        if (err_cnt !== 16'd0) begin n_miss++; $display("FAIL rst_mid_errcnt: got %0d want 0", err_cnt); end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1;
        run_read(4'd7, 64'h1_0010, 8'd0, 3'd3, BURST_INCR, -1, 0);
        exp = {romv(2), RESP_OKAY, 1'b1, 1'b1};
        got = {g_data[0], g_resp[0], g_last[0], (g_n == 1) && (g_gap[0] == 3) && (g_id[0] == 4'd7)};
        n_vec++;
        if (got !== exp) begin n_miss++; $display("FAIL rst_mid_next: got %h want %h", got, exp); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_error();
        test_backpressure();
        test_concurrent();
        test_reset_midburst();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
